nibble_serial_adder: RTL and testbench

Sequencing stage that drives an external 4-bit ripple-carry adder (A/B/Cin in, Sum/Cout out) to add or subtract two NIBBLES×4-bit operands, one nibble per clock. It latches the operands, presents one nibble pair per cycle least-significant first, and registers the adder's carry-out as the next nibble's carry-in. It collects each Sum nibble into a result register. It sits between the datapath's operand source and the adder, and provides a start/busy/done handshake upstream.

---
 rtl/nibble_serial_adder_if.sv | 33 +++
 rtl/nibble_serial_adder.sv | 104 ++++++++++
 tb/tb_nibble_serial_adder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Bundle between the nibble sequencer, its upstream operand source and the
// external 4-bit adder. The slave modport is the sequencer's view.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [3:0]   add_A;
    logic [3:0]   add_B;
    logic         add_Cin;
    logic [3:0]   add_Sum;
    logic         add_Cout;

    modport slave (
        input  start, sub, cin, op_a, op_b, add_Sum, add_Cout,
        output busy, done, result, cout, ovf, add_A, add_B, add_Cin
    );

    modport master (
        output start, sub, cin, op_a, op_b, add_Sum, add_Cout,
        input  busy, done, result, cout, ovf, add_A, add_B, add_Cin
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Drives an external combinational 4-bit adder one nibble per clock, LSB first,
// chaining the carry through a register; subtraction is ~B plus inverted borrow.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [3:0]      a_nib [NIBBLES];
    logic [3:0]      b_nib [NIBBLES];
    logic            in_run;
    logic            last_nib;

    assign in_run   = (state_q == RUN);
    assign last_nib = (idx_q == IW'(NIBBLES - 1));

    // Only the nibble currently at the adder is replaced; the rest hold.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_q[4*gi +: 4];
        assign b_nib[gi] = b_q[4*gi +: 4];
        assign result_d[4*gi +: 4] = (in_run && idx_q == IW'(gi)) ? bus.add_Sum
                                                                  : result_q[4*gi +: 4];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.op_a;
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = bus.add_Cout;
                idx_d   = idx_q + 1'b1;
                if (last_nib) begin
                    state_d = DONE;
                    cout_d  = bus.add_Cout;
                    // Sign rule on the effective operands covers subtract too.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_Sum[3] != a_q[W-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.busy    = in_run;
    assign bus.done    = (state_q == DONE);
    assign bus.result  = result_q;
    assign bus.cout    = cout_q;
    assign bus.ovf     = ovf_q;
    assign bus.add_A   = in_run ? a_nib[idx_q] : 4'h0;
    assign bus.add_B   = in_run ? b_nib[idx_q] : 4'h0;
    assign bus.add_Cin = in_run ? carry_q : 1'b0;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: fixed vectors, handshake/reset corner cases and
// random operations against an integer-arithmetic reference.
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst_n;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) ifc ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // The external combinational adder.
    assign {ifc.add_Cout, ifc.add_Sum} = {1'b0, ifc.add_A} + {1'b0, ifc.add_B} + {4'b0000, ifc.add_Cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           s;
        bit           c;
        logic [W-1:0] r;
        bit           co;
        bit           ov;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the whole word.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit s, input bit c,
                                  output logic [W-1:0] r, output bit co, output bit ov);
        longint ua, ub, sa, sb, u, sv;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            u  = ua - ub - longint'(c);
            sv = sa - sb - longint'(c);
            co = (u >= 0);
        end else begin
            u  = ua + ub + longint'(c);
            sv = sa + sb + longint'(c);
            co = (u >= (longint'(1) << W));
        end
        r  = u[W-1:0];
        ov = (sv > ((longint'(1) << (W-1)) - 1)) || (sv < -(longint'(1) << (W-1)));
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge
    // where done is seen (done_at = cycles after the accept edge, 0 = timeout).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit c,
                         input bit hold_start, output int busy_n, output int done_at);
        ifc.op_a  = a;
        ifc.op_b  = b;
        ifc.sub   = s;
        ifc.cin   = c;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) ifc.start = 1'b0;
        busy_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ifc.busy) busy_n++;
            if (ifc.done) begin
                done_at = k;
                break;
            end
        end
    endtask

    task automatic wait_done(output int done_at);
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ifc.done) begin
                done_at = k;
                break;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    ifc.busy,    0);
        check({tag, "_done"},    ifc.done,    0);
        check({tag, "_result"},  ifc.result,  0);
        check({tag, "_cout"},    ifc.cout,    0);
        check({tag, "_ovf"},     ifc.ovf,     0);
        check({tag, "_add_A"},   ifc.add_A,   0);
        check({tag, "_add_B"},   ifc.add_B,   0);
        check({tag, "_add_Cin"}, ifc.add_Cin, 0);
    endtask

    initial begin
        int           busy_n, done_at;
        logic [W-1:0] er;
        bit           eco, eov;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};

        ifc.start = 1'b0;
        ifc.sub   = 1'b0;
        ifc.cin   = 1'b0;
        ifc.op_a  = '0;
        ifc.op_b  = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed vectors with latency and single-pulse checks.
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'b0, busy_n, done_at);
            $display("vec %0d: a=%h b=%h sub=%0d cin=%0d -> result=%h cout=%0d ovf=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, ifc.result, ifc.cout, ifc.ovf);
            check($sformatf("vec%0d_done_at", i), done_at, NIBBLES + 1);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, NIBBLES);
            check($sformatf("vec%0d_result", i), ifc.result, vecs[i].r);
            check($sformatf("vec%0d_cout", i), ifc.cout, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), ifc.ovf, vecs[i].ov);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), ifc.done, 0);
            check($sformatf("vec%0d_result_held", i), ifc.result, vecs[i].r);
        end

        // Carry-in: watch the adder ports nibble by nibble.
        ifc.op_a = 16'h00FF; ifc.op_b = 16'h0000; ifc.sub = 1'b0; ifc.cin = 1'b1; ifc.start = 1'b1;
        @(posedge clk); #1; ifc.start = 1'b0;
        @(negedge clk);
        check("cin_nib0_add_Cin", ifc.add_Cin, 1);
        check("cin_nib0_add_A", ifc.add_A, 4'hF);
        @(negedge clk);
        check("cin_nib1_add_Cin", ifc.add_Cin, 1);
        @(negedge clk);
        check("cin_nib2_add_Cin", ifc.add_Cin, 1);
        check("cin_nib2_add_Sum", ifc.add_Sum, 4'h1);
        wait_done(done_at);
        check("cin_done_at", done_at, 2);
        check("cin_result", ifc.result, 16'h0100);
        $display("carry-in op: result=%h cout=%0d", ifc.result, ifc.cout);
        @(negedge clk);
        check("idle_add_Cin", ifc.add_Cin, 0);

        // Start pulsed mid-RUN with other operands must be ignored.
        ifc.op_a = 16'h1111; ifc.op_b = 16'h2222; ifc.sub = 1'b0; ifc.cin = 1'b0; ifc.start = 1'b1;
        @(posedge clk); #1; ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        ifc.op_a = 16'hAAAA; ifc.op_b = 16'h5555; ifc.sub = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(done_at);
        check("midrun_done_at", done_at, 2);
        check("midrun_result", ifc.result, 16'h3333);
        check("midrun_cout", ifc.cout, 0);
        $display("mid-run start ignored: result=%h", ifc.result);
        @(negedge clk);
        check("midrun_no_restart", ifc.busy, 0);

        // Start held through DONE: second op follows with no idle cycle.
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, busy_n, done_at);
        check("b2b_first_done_at", done_at, NIBBLES + 1);
        check("b2b_first_result", ifc.result, 16'h2233);
        ifc.op_a = 16'h0005; ifc.op_b = 16'h0007; ifc.sub = 1'b1; ifc.cin = 1'b0;
        @(negedge clk);
        check("b2b_no_idle", ifc.busy, 1);
        ifc.start = 1'b0;
        wait_done(done_at);
        check("b2b_second_done_at", done_at, NIBBLES);
        check("b2b_second_result", ifc.result, 16'hFFFE);
        check("b2b_second_cout", ifc.cout, 0);
        $display("back-to-back: second result=%h", ifc.result);
        @(negedge clk);

        // Asynchronous reset during nibble 2.
        ifc.op_a = 16'h1234; ifc.op_b = 16'h1111; ifc.sub = 1'b0; ifc.cin = 1'b0; ifc.start = 1'b1;
        @(posedge clk); #1; ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        done_at = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ifc.done || ifc.busy) done_at = 1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_no_done", done_at, 0);
        do_op(vecs[0].a, vecs[0].b, vecs[0].s, vecs[0].c, 1'b0, busy_n, done_at);
        check("post_reset_done_at", done_at, NIBBLES + 1);
        check("post_reset_result", ifc.result, vecs[0].r);
        $display("after mid-op reset: result=%h", ifc.result);
        @(negedge clk);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            bit           rs, rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            if (i < 4) begin
                ra = (i[0]) ? 16'h8000 : 16'h7FFF;
                rb = (i[1]) ? 16'hFFFF : 16'h8000;
            end
            model(ra, rb, rs, rc, er, eco, eov);
            do_op(ra, rb, rs, rc, 1'b0, busy_n, done_at);
            $display("rand %0d: a=%h b=%h sub=%0d cin=%0d -> result=%h cout=%0d ovf=%0d",
                     i, ra, rb, rs, rc, ifc.result, ifc.cout, ifc.ovf);
            check($sformatf("rand%0d_done_at", i), done_at, NIBBLES + 1);
            check($sformatf("rand%0d_result", i), ifc.result, er);
            check($sformatf("rand%0d_cout", i), ifc.cout, eco);
            check($sformatf("rand%0d_ovf", i), ifc.ovf, eov);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end
endmodule
